mul_hilo_stage: RTL and testbench
=================================

Name: mul_hilo_stage

Overview:
- Sequencing stage wrapped around the combinational 32x32 signed Booth multiplier.
- Registers the operands and drives them to the multiplier. Waits a fixed multicycle budget, then captures the 64-bit product into the HI/LO register pair.
- Sits between the datapath bus/control unit and the multiplier; HI/LO feed the bus for MFHI/MFLO.
- Also supports direct bus writes to HI/LO (MTHI/MTLO).

Parameters:
- MUL_LATENCY, 2, clock cycles allowed for the multiplier combinational path; legal range 1..15; 0 is illegal.

Ports:
- clock  in  1  single clock, rising edge
- clear_n  in  1  asynchronous active-low reset
- start  in  1  request multiply of op_a*op_b; sampled only in IDLE
- op_a  in  32  signed multiplicand
- op_b  in  32  signed multiplier
- mul_a  out  32  registered operand A to the multiplier
- mul_b  out  32  registered operand B to the multiplier
- mul_z  in  64  signed product returned by the multiplier
- bus_in  in  32  datapath bus for direct HI/LO writes
- hi_wr  in  1  write bus_in to HI
- lo_wr  in  1  write bus_in to LO
- hi  out  32  HI register (product[63:32])
- lo  out  32  LO register (product[31:0])
- busy  out  1  high while in EXEC
- done  out  1  one-cycle pulse, registered, in the cycle HI/LO first show a new product

Behaviour:
- Reset (clear_n low, asynchronous):
  - mul_a, mul_b, hi, lo = 0; busy = 0; done = 0; state = IDLE; counter = 0.
  - Release is synchronous to the next edge.
- States:
  - IDLE: start=1 at an edge loads mul_a<=op_a, mul_b<=op_b, cnt<=MUL_LATENCY-1, state<=EXEC.
  - EXEC: if cnt!=0, cnt<=cnt-1. If cnt==0, hi<=mul_z[63:32], lo<=mul_z[31:0], done<=1, state<=IDLE.
- Latency: start accepted at edge N; HI/LO updated at edge N+MUL_LATENCY; done high for exactly the following cycle.
- done is deasserted at every edge except the capture edge.
- busy = (state==EXEC), driven from the state register, not from a combinational decode of inputs.
- Back-to-back operation: start may be asserted in the cycle done is high (state is IDLE); the new operands load at that edge.
- start while busy is ignored; nothing is queued.
- Bus writes:
  - hi_wr/lo_wr are honoured only in IDLE and are ignored in EXEC.
  - hi_wr and lo_wr together write bus_in to both registers.
  - A bus write and start at the same IDLE edge: the bus write lands, and the product later overwrites HI/LO.
- mul_a/mul_b hold their value after capture until the next accepted start.
- Arithmetic: the stage does no arithmetic; mul_z is taken as a two's-complement 64-bit value and split without modification.
- Reset mid-EXEC: the operation is abandoned, HI/LO = 0, and no done pulse is produced.

Optional Feature:
- Macro: MUL_OVERFLOW_FLAG_EN.
- Defined:
  - Adds output port ovf (1 bit), reset 0.
  - Updated only at the capture edge: ovf <= (mul_z[63:32] != {32{mul_z[31]}}), i.e. the product does not fit in 32 signed bits.
  - A bus write to HI or LO clears ovf.
- Undefined: the port is absent and no logic is generated.

Decomposition:
- Package mul_hilo_pkg:
  - constants WORD_W=32 and PROD_W=64
  - state enum type (IDLE, EXEC)
  - function returning the counter width, clog2(MUL_LATENCY)
- Sub-module mul_latency_counter: loadable down-counter with a zero flag, parameterised by MUL_LATENCY. It is instantiated once.
- The HI/LO registers and the FSM live in the top.

Test Plan:
- Reset, then MUL_LATENCY=2: start with op_a=7, op_b=-3 (0xFFFFFFFD). Required: busy for 2 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB; one done pulse.
- op_a=op_b=0x80000000, MUL_LATENCY=1. Required: hi=0x40000000, lo=0x00000000 one edge after start; with MUL_OVERFLOW_FLAG_EN, ovf=1.
- Assert start again with new operands (5, 6) while busy. Required: ignored; first result unaffected. Then start in the done cycle. Required: accepted; hi=0, lo=30 two edges later.
- In IDLE, hi_wr=1 with bus_in=0x12345678. Required: hi=0x12345678, lo unchanged. Then hi_wr during EXEC. Required: ignored.
- Start with (100, 200), then drop clear_n in the second EXEC cycle. Required: immediate hi=lo=0, busy=0, no done pulse ever; a fresh start afterwards works normally.
- With MUL_OVERFLOW_FLAG_EN: -1 * 1. Required: ovf=0, hi=0xFFFFFFFF, lo=0xFFFFFFFF. Then 0x10000 * 0x10000. Required: ovf=1, hi=1, lo=0.

Source files
------------

// File: rtl/mul_hilo_pkg.sv
// mul_hilo_pkg: shared constants, FSM state type and counter-width helper
// for the mul_hilo_stage multiply sequencing stage.
package mul_hilo_pkg;

  localparam int WORD_W = 32;
  localparam int PROD_W = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // Counter width is clog2(MUL_LATENCY), floored at one bit so that
  // MUL_LATENCY=1 (load value 0) still yields a legal vector.
  function automatic int cnt_width(input int latency);
    int w;
    w = $clog2(latency);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mul_hilo_stage_if.sv
// mul_hilo_stage_if: groups the control, operand, product and HI/LO bus
// signals of mul_hilo_stage.
//   slave  : the stage itself (takes start/operands/mul_z/bus writes,
//            drives mul_a/mul_b/hi/lo/busy/done)
//   master : the control unit / datapath side
// Optional macro MUL_OVERFLOW_FLAG_EN adds the ovf signal.
interface mul_hilo_stage_if;
  import mul_hilo_pkg::*;

  logic              start;
  logic [WORD_W-1:0] op_a;
  logic [WORD_W-1:0] op_b;
  logic [WORD_W-1:0] mul_a;
  logic [WORD_W-1:0] mul_b;
  logic [PROD_W-1:0] mul_z;
  logic [WORD_W-1:0] bus_in;
  logic              hi_wr;
  logic              lo_wr;
  logic [WORD_W-1:0] hi;
  logic [WORD_W-1:0] lo;
  logic              busy;
  logic              done;
`ifdef MUL_OVERFLOW_FLAG_EN
  logic              ovf;
`endif

  modport slave (
    input  start, op_a, op_b, mul_z, bus_in, hi_wr, lo_wr,
`ifdef MUL_OVERFLOW_FLAG_EN
    output ovf,
`endif
    output mul_a, mul_b, hi, lo, busy, done
  );

  modport master (
    output start, op_a, op_b, mul_z, bus_in, hi_wr, lo_wr,
`ifdef MUL_OVERFLOW_FLAG_EN
    input  ovf,
`endif
    input  mul_a, mul_b, hi, lo, busy, done
  );

endinterface

// File: rtl/mul_latency_counter.sv
// mul_latency_counter: loadable down-counter with zero flag that times the
// multiplier's multicycle budget.
//   i_clock   : rising-edge clock
//   i_clear_n : asynchronous active-low reset (count -> 0)
//   i_load    : load MUL_LATENCY-1
//   i_dec     : decrement by one (saturates at zero)
//   o_zero    : count is zero
module mul_latency_counter
  import mul_hilo_pkg::*;
#(
  parameter int MUL_LATENCY = 2
) (
  input  logic i_clock,
  input  logic i_clear_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int CNT_W = cnt_width(MUL_LATENCY);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] ONE_VAL  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_VAL = CNT_W'(0);

  logic [CNT_W-1:0] r_cnt;

  // Count register: load has priority over decrement.
  always_ff @(posedge i_clock or negedge i_clear_n) begin
    if (!i_clear_n) begin
      r_cnt <= ZERO_VAL;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_dec && (r_cnt != ZERO_VAL)) begin
      r_cnt <= r_cnt - ONE_VAL;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == ZERO_VAL);

endmodule

// File: rtl/mul_hilo_stage.sv
// mul_hilo_stage: registers operands for the external combinational
// multiplier, waits MUL_LATENCY cycles, then captures the 64-bit product
// into HI/LO. HI/LO can also be written from the datapath bus while idle.
//   clock   : rising-edge clock
//   clear_n : asynchronous active-low reset
//   bus     : mul_hilo_stage_if.slave (start/op_a/op_b, mul_a/mul_b/mul_z,
//             bus_in/hi_wr/lo_wr, hi/lo, busy/done[, ovf])
// Optional macro MUL_OVERFLOW_FLAG_EN adds the ovf flag.
module mul_hilo_stage
  import mul_hilo_pkg::*;
#(
  parameter int MUL_LATENCY = 2
) (
  input  logic              clock,
  input  logic              clear_n,
  mul_hilo_stage_if.slave   bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_capture;
  logic              w_cnt_zero;
  logic [WORD_W-1:0] r_mul_a;
  logic [WORD_W-1:0] r_mul_b;
  logic [WORD_W-1:0] r_hi;
  logic [WORD_W-1:0] r_lo;
  logic              r_done;
  logic [PROD_W-1:0] w_prod;

  assign w_prod = bus.mul_z;

  mul_latency_counter #(
    .MUL_LATENCY (MUL_LATENCY)
  ) u_cnt (
    .i_clock   (clock),
    .i_clear_n (clear_n),
    .i_load    (w_accept),
    .i_dec     (r_state == EXEC),
    .o_zero    (w_cnt_zero)
  );

  // Next-state decode: accept start in IDLE, capture when the budget expires.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = EXEC;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      EXEC: begin
        if (w_cnt_zero) begin
          w_state_nxt = IDLE;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = EXEC;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand registers hold after capture until the next accepted start.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_mul_a <= {WORD_W{1'b0}};
      r_mul_b <= {WORD_W{1'b0}};
    end else if (w_accept) begin
      r_mul_a <= bus.op_a;
      r_mul_b <= bus.op_b;
    end else begin
      r_mul_a <= r_mul_a;
      r_mul_b <= r_mul_b;
    end
  end

  // HI/LO: product capture, else bus writes (only honoured while idle).
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_hi <= {WORD_W{1'b0}};
      r_lo <= {WORD_W{1'b0}};
    end else if (w_capture) begin
      r_hi <= w_prod[PROD_W-1:WORD_W];
      r_lo <= w_prod[WORD_W-1:0];
    end else if (r_state == IDLE) begin
      if (bus.hi_wr) begin
        r_hi <= bus.bus_in;
      end
      if (bus.lo_wr) begin
        r_lo <= bus.bus_in;
      end
    end
  end

  // done pulses only in the cycle after the capture edge.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_capture;
    end
  end

`ifdef MUL_OVERFLOW_FLAG_EN
  logic r_ovf;

  // Overflow: product does not fit in 32 signed bits; bus writes clear it.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_ovf <= 1'b0;
    end else if (w_capture) begin
      r_ovf <= (w_prod[PROD_W-1:WORD_W] != {WORD_W{w_prod[WORD_W-1]}});
    end else if ((r_state == IDLE) && (bus.hi_wr || bus.lo_wr)) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.mul_a = r_mul_a;
  assign bus.mul_b = r_mul_b;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
  assign bus.busy  = (r_state == EXEC);
  assign bus.done  = r_done;

endmodule

// File: tb/tb_mul_hilo_stage.sv
// tb_mul_hilo_stage: directed bench for mul_hilo_stage. Two instances share
// clock/reset: u_dut2 (MUL_LATENCY=2) and u_dut1 (MUL_LATENCY=1). Each has a
// behavioural multiplier closing the mul_a/mul_b -> mul_z loop.
module tb_mul_hilo_stage;

  logic clock;
  logic clear_n;
  int   checks;
  int   failures;

  mul_hilo_stage_if if2 ();
  mul_hilo_stage_if if1 ();

  mul_hilo_stage #(.MUL_LATENCY(2)) u_dut2 (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (if2)
  );

  mul_hilo_stage #(.MUL_LATENCY(1)) u_dut1 (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (if1)
  );

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign if2.mul_z = {{32{if2.mul_a[31]}}, if2.mul_a} * {{32{if2.mul_b[31]}}, if2.mul_b};
  assign if1.mul_z = {{32{if1.mul_a[31]}}, if1.mul_a} * {{32{if1.mul_b[31]}}, if1.mul_b};

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clock = 1'b0;
    clear_n = 1'b0;
    checks = 0;
    failures = 0;
    if2.start = 1'b0; if2.op_a = 32'h0; if2.op_b = 32'h0;
    if2.bus_in = 32'h0; if2.hi_wr = 1'b0; if2.lo_wr = 1'b0;
    if1.start = 1'b0; if1.op_a = 32'h0; if1.op_b = 32'h0;
    if1.bus_in = 32'h0; if1.hi_wr = 1'b0; if1.lo_wr = 1'b0;

    #12;
    chk("rst_hi", if2.hi, 32'h0);
    chk("rst_lo", if2.lo, 32'h0);
    chk("rst_busy", {31'h0, if2.busy}, 32'h0);
    chk("rst_done", {31'h0, if2.done}, 32'h0);
    chk("rst_mul_a", if2.mul_a, 32'h0);
    chk("rst_mul_b", if2.mul_b, 32'h0);
    clear_n = 1'b1;
    tick();

    // 7 * -3 = -21
    if2.start = 1'b1; if2.op_a = 32'd7; if2.op_b = 32'hFFFFFFFD;
    tick();
    if2.start = 1'b0;
    chk("t1_busy_c1", {31'h0, if2.busy}, 32'h1);
    chk("t1_mul_a", if2.mul_a, 32'd7);
    chk("t1_mul_b", if2.mul_b, 32'hFFFFFFFD);
    chk("t1_done_c1", {31'h0, if2.done}, 32'h0);
    tick();
    chk("t1_busy_c2", {31'h0, if2.busy}, 32'h1);
    chk("t1_hi_early", if2.hi, 32'h0);
    tick();
    chk("t1_busy_end", {31'h0, if2.busy}, 32'h0);
    chk("t1_done", {31'h0, if2.done}, 32'h1);
    chk("t1_hi", if2.hi, 32'hFFFFFFFF);
    chk("t1_lo", if2.lo, 32'hFFFFFFEB);
    tick();
    chk("t1_done_off", {31'h0, if2.done}, 32'h0);
    chk("t1_hi_hold", if2.hi, 32'hFFFFFFFF);
    chk("t1_mul_a_hold", if2.mul_a, 32'd7);

    // 0x10000 * 0x10000 = 2^32; start during EXEC ignored, then taken in done cycle
    if2.start = 1'b1; if2.op_a = 32'h00010000; if2.op_b = 32'h00010000;
    tick();
    if2.op_a = 32'd5; if2.op_b = 32'd6;
    chk("t3_busy", {31'h0, if2.busy}, 32'h1);
    tick();
    chk("t3_ign_mul_a", if2.mul_a, 32'h00010000);
    chk("t3_ign_busy", {31'h0, if2.busy}, 32'h1);
    tick();
    chk("t3_done", {31'h0, if2.done}, 32'h1);
    chk("t3_hi", if2.hi, 32'h1);
    chk("t3_lo", if2.lo, 32'h0);
`ifdef MUL_OVERFLOW_FLAG_EN
    chk("t3_ovf", {31'h0, if2.ovf}, 32'h1);
`endif
    tick();
    if2.start = 1'b0;
    chk("t3_b2b_busy", {31'h0, if2.busy}, 32'h1);
    chk("t3_b2b_mul_a", if2.mul_a, 32'd5);
    chk("t3_b2b_done_off", {31'h0, if2.done}, 32'h0);
    tick();
    tick();
    chk("t3_b2b_done", {31'h0, if2.done}, 32'h1);
    chk("t3_b2b_hi", if2.hi, 32'h0);
    chk("t3_b2b_lo", if2.lo, 32'd30);

    // Bus writes in IDLE
    if2.hi_wr = 1'b1; if2.bus_in = 32'h12345678;
    tick();
    if2.hi_wr = 1'b0;
    chk("t4_hi_wr", if2.hi, 32'h12345678);
    chk("t4_lo_keep", if2.lo, 32'd30);
    if2.hi_wr = 1'b1; if2.lo_wr = 1'b1; if2.bus_in = 32'hA5A5A5A5;
    tick();
    if2.hi_wr = 1'b0; if2.lo_wr = 1'b0;
    chk("t4_both_hi", if2.hi, 32'hA5A5A5A5);
    chk("t4_both_lo", if2.lo, 32'hA5A5A5A5);

    // Bus write with start lands; EXEC write ignored; product overwrites
    if2.start = 1'b1; if2.op_a = 32'd3; if2.op_b = 32'd4;
    if2.hi_wr = 1'b1; if2.bus_in = 32'h11111111;
    tick();
    if2.start = 1'b0; if2.bus_in = 32'h22222222;
    chk("t4_wr_start_hi", if2.hi, 32'h11111111);
`ifdef MUL_OVERFLOW_FLAG_EN
    chk("t4_ovf_clr", {31'h0, if2.ovf}, 32'h0);
`endif
    tick();
    if2.hi_wr = 1'b0;
    chk("t4_exec_wr_ign", if2.hi, 32'h11111111);
    tick();
    chk("t4_prod_hi", if2.hi, 32'h0);
    chk("t4_prod_lo", if2.lo, 32'd12);

    // -1 * 1
    if2.start = 1'b1; if2.op_a = 32'hFFFFFFFF; if2.op_b = 32'd1;
    tick();
    if2.start = 1'b0;
    tick();
    tick();
    chk("t6_hi", if2.hi, 32'hFFFFFFFF);
    chk("t6_lo", if2.lo, 32'hFFFFFFFF);
`ifdef MUL_OVERFLOW_FLAG_EN
    chk("t6_ovf", {31'h0, if2.ovf}, 32'h0);
`endif

    // Reset in the second EXEC cycle
    if2.start = 1'b1; if2.op_a = 32'd100; if2.op_b = 32'd200;
    tick();
    if2.start = 1'b0;
    tick();
    chk("t5_busy_pre", {31'h0, if2.busy}, 32'h1);
    #2;
    clear_n = 1'b0;
    #1;
    chk("t5_rst_hi", if2.hi, 32'h0);
    chk("t5_rst_lo", if2.lo, 32'h0);
    chk("t5_rst_busy", {31'h0, if2.busy}, 32'h0);
    chk("t5_rst_done", {31'h0, if2.done}, 32'h0);
    tick();
    chk("t5_held_done", {31'h0, if2.done}, 32'h0);
    #3;
    clear_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_done", {31'h0, if2.done}, 32'h0);
      chk("t5_no_busy", {31'h0, if2.busy}, 32'h0);
    end
    if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
    chk("t5_restart_busy", {31'h0, if2.busy}, 32'h1);
    tick();
    tick();
    chk("t5_restart_done", {31'h0, if2.done}, 32'h1);
    chk("t5_restart_hi", if2.hi, 32'h0);
    chk("t5_restart_lo", if2.lo, 32'h00004E20);

    // MUL_LATENCY=1: 0x80000000 * 0x80000000 = 2^62
    if1.start = 1'b1; if1.op_a = 32'h80000000; if1.op_b = 32'h80000000;
    tick();
    if1.start = 1'b0;
    chk("t2_busy", {31'h0, if1.busy}, 32'h1);
    chk("t2_hi_early", if1.hi, 32'h0);
    tick();
    chk("t2_done", {31'h0, if1.done}, 32'h1);
    chk("t2_busy_end", {31'h0, if1.busy}, 32'h0);
    chk("t2_hi", if1.hi, 32'h40000000);
    chk("t2_lo", if1.lo, 32'h0);
`ifdef MUL_OVERFLOW_FLAG_EN
    chk("t2_ovf", {31'h0, if1.ovf}, 32'h1);
`endif
    tick();
    chk("t2_done_off", {31'h0, if1.done}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
